// File: rtl/pipelined_fetch_decode_if.sv
// Bus between the fetch/decode front end and its neighbours: load port,
// hazard/branch feedback from EX, and the decoded ID-stage outputs.
interface pipelined_fetch_decode_if #(
  parameter int ADDR_W = 7
);
  logic              load_en;
  logic [ADDR_W-1:0] load_adx;
  logic [31:0]       instr_in;
  logic              stall;
  logic              br_taken_ex;
  logic [ADDR_W-1:0] br_target_ex;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] id_pc;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [4:0]        regAdx1;
  logic [4:0]        regAdx2;
  logic [4:0]        writeAdx;
  logic [31:0]       imd;
  logic [ADDR_W-1:0] br_target_id;
  logic              j;
  logic              br;
  logic              regWR;
  logic              Mem2Reg;
  logic              MemWrEn;
  logic              ALUsrc;
  logic              RegDst;
  logic [1:0]        ALUop;
  logic              illegal;

  // master drives loads and EX feedback; slave is the fetch/decode block.
  modport master (
    output load_en, load_adx, instr_in, stall, br_taken_ex, br_target_ex,
    input  pc, id_pc, id_valid, id_instr, regAdx1, regAdx2, writeAdx, imd,
           br_target_id, j, br, regWR, Mem2Reg, MemWrEn, ALUsrc, RegDst,
           ALUop, illegal
  );

  modport slave (
    input  load_en, load_adx, instr_in, stall, br_taken_ex, br_target_ex,
    output pc, id_pc, id_valid, id_instr, regAdx1, regAdx2, writeAdx, imd,
           br_target_id, j, br, regWR, Mem2Reg, MemWrEn, ALUsrc, RegDst,
           ALUop, illegal
  );
endinterface

// File: rtl/pipelined_fetch_decode.sv
// Pipelined CPU front end: loadable imem, PC, IF/ID register and main decoder,
// with stall, jump redirect in ID and taken-branch redirect from EX.
module pipelined_fetch_decode #(
  parameter int ADDR_W   = 7,
  parameter int DEPTH    = 128,
  parameter int RESET_PC = 0
) (
  input logic                    clk,
  input logic                    rst,
  pipelined_fetch_decode_if.slave bus
);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0]       r_imem [DEPTH];
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_id_pc;
  logic [31:0]       r_id_instr;
  logic              r_id_valid;

  logic [31:0]       w_fetch;
  logic [5:0]        w_opcode;
  logic              w_id_jump;
  logic [31:0]       w_imd;
  logic [8:0]        w_ctrl;
  logic              w_illegal;

  assign w_fetch   = r_imem[r_pc];
  assign w_opcode  = r_id_instr[31:26];
  assign w_id_jump = r_id_valid && (w_opcode == OP_J);
  assign w_imd     = {{16{r_id_instr[15]}}, r_id_instr[15:0]};

  // Memory contents survive reset so a program loaded once can be rerun.
  always_ff @(posedge clk) begin
    if (bus.load_en) r_imem[bus.load_adx] <= bus.instr_in;
  end

  // Priority: load > EX branch (flush, beats stall) > stall > ID jump > sequential.
  // Invalidated ID slots also clear their instruction so id_instr reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RST_PC;
      r_id_pc    <= '0;
      r_id_instr <= '0;
      r_id_valid <= 1'b0;
    end else if (bus.load_en) begin
      r_pc       <= RST_PC;
      r_id_instr <= '0;
      r_id_valid <= 1'b0;
    end else if (bus.br_taken_ex) begin
      r_pc       <= bus.br_target_ex;
      r_id_instr <= '0;
      r_id_valid <= 1'b0;
    end else if (bus.stall) begin
      r_pc       <= r_pc;
    end else if (w_id_jump) begin
      r_pc       <= r_id_instr[ADDR_W-1:0];
      r_id_instr <= '0;
      r_id_valid <= 1'b0;
    end else begin
      r_pc       <= r_pc + ADDR_W'(1);
      r_id_pc    <= r_pc;
      r_id_instr <= w_fetch;
      r_id_valid <= 1'b1;
    end
  end

  // w_ctrl = {regWR, Mem2Reg, MemWrEn, ALUsrc, RegDst, br, j, ALUop[1:0]}
  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    if (r_id_valid) begin
      case (w_opcode)
        OP_RTYPE: w_ctrl = 9'b1_0_0_0_1_0_0_10;
        OP_LW:    w_ctrl = 9'b1_1_0_1_0_0_0_00;
        OP_SW:    w_ctrl = 9'b0_0_1_1_0_0_0_00;
        OP_ADDI:  w_ctrl = 9'b1_0_0_1_0_0_0_00;
        OP_BEQ:   w_ctrl = 9'b0_0_0_0_0_1_0_01;
        OP_J:     w_ctrl = 9'b0_0_0_0_0_0_1_00;
        default:  w_illegal = 1'b1;
      endcase
    end
  end

  assign bus.pc           = r_pc;
  assign bus.id_pc        = r_id_pc;
  assign bus.id_valid     = r_id_valid;
  assign bus.id_instr     = r_id_instr;
  assign bus.regAdx1      = r_id_instr[25:21];
  assign bus.regAdx2      = r_id_instr[20:16];
  assign bus.writeAdx     = w_ctrl[4] ? r_id_instr[15:11] : r_id_instr[20:16];
  assign bus.imd          = w_imd;
  assign bus.br_target_id = r_id_pc + ADDR_W'(1) + w_imd[ADDR_W-1:0];
  assign bus.regWR        = w_ctrl[8];
  assign bus.Mem2Reg      = w_ctrl[7];
  assign bus.MemWrEn      = w_ctrl[6];
  assign bus.ALUsrc       = w_ctrl[5];
  assign bus.RegDst       = w_ctrl[4];
  assign bus.br           = w_ctrl[3];
  assign bus.j            = w_ctrl[2];
  assign bus.ALUop        = w_ctrl[1:0];
  assign bus.illegal      = w_illegal;
endmodule

// File: tb/tb_pipelined_fetch_decode.sv
// Directed bench for pipelined_fetch_decode: load, sequential fetch, jump,
// EX branch flush, stall, PC wrap, illegal opcode and async reset.
module tb_pipelined_fetch_decode;
  localparam logic [31:0] I_ADDI  = 32'h2022_0005; // addi $2,$1,5
  localparam logic [31:0] I_ADDI2 = 32'h2003_0007; // addi $3,$0,7
  localparam logic [31:0] I_RTYPE = 32'h0022_1820; // add  $3,$1,$2
  localparam logic [31:0] I_LW    = 32'h8C24_FFFC; // lw   $4,-4($1)
  localparam logic [31:0] I_SW    = 32'hAC24_0008; // sw   $4,8($1)
  localparam logic [31:0] I_J10   = 32'h0800_0010; // j    0x10
  localparam logic [31:0] I_J126  = 32'h0800_007E; // j    126
  localparam logic [31:0] I_BEQ   = 32'h1022_FFFD; // beq  $1,$2,-3
  localparam logic [31:0] I_BAD   = 32'hFC00_0000; // opcode 111111

  // {regWR, Mem2Reg, MemWrEn, ALUsrc, RegDst, br, j, ALUop}
  localparam logic [8:0] C_ADDI = 9'b100100000;
  localparam logic [8:0] C_R    = 9'b100010010;
  localparam logic [8:0] C_LW   = 9'b110100000;
  localparam logic [8:0] C_SW   = 9'b001100000;
  localparam logic [8:0] C_BEQ  = 9'b000001001;
  localparam logic [8:0] C_J    = 9'b000000100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_fetch_decode_if #(.ADDR_W(7)) bus ();

  pipelined_fetch_decode #(.ADDR_W(7), .DEPTH(128), .RESET_PC(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wire [8:0] ctrl_vec = {bus.regWR, bus.Mem2Reg, bus.MemWrEn, bus.ALUsrc,
                         bus.RegDst, bus.br, bus.j, bus.ALUop};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [6:0] a, input logic [31:0] d);
    bus.load_en  = 1'b1;
    bus.load_adx = a;
    bus.instr_in = d;
    tick();
  endtask

  task automatic release_load();
    bus.load_en = 1'b0;
    check_eq("pc_after_load", 32'(bus.pc), 32'd0);
    check_eq("valid_after_load", 32'(bus.id_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  exp_ctrl [4];
    logic [4:0]  exp_wadx [4];
    logic [4:0]  exp_rs2  [4];
    logic [31:0] exp_imd  [4];
    exp_ctrl = '{C_ADDI, C_R, C_LW, C_SW};
    exp_wadx = '{5'd2, 5'd3, 5'd4, 5'd4};
    exp_rs2  = '{5'd2, 5'd2, 5'd4, 5'd4};
    exp_imd  = '{32'h5, 32'h1820, 32'hFFFF_FFFC, 32'h8};

    bus.load_en = 1'b0; bus.load_adx = '0; bus.instr_in = '0;
    bus.stall = 1'b0; bus.br_taken_ex = 1'b0; bus.br_target_ex = '0;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", 32'(bus.pc), 32'd0);
    check_eq("rst_valid", 32'(bus.id_valid), 32'd0);
    check_eq("rst_id_pc", 32'(bus.id_pc), 32'd0);
    check_eq("rst_id_instr", bus.id_instr, 32'd0);
    check_eq("rst_ctrl", 32'(ctrl_vec), 32'd0);
    rst = 1'b0;

    // Sequential fetch of ADDI, R, LW, SW
    load_word(7'd0, I_ADDI);
    load_word(7'd1, I_RTYPE);
    check_eq("load_pc_hold", 32'(bus.pc), 32'd0);
    load_word(7'd2, I_LW);
    load_word(7'd3, I_SW);
    release_load();
    exp_q.push_back(I_ADDI); exp_q.push_back(I_RTYPE);
    exp_q.push_back(I_LW);   exp_q.push_back(I_SW);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("seq_pc", 32'(bus.pc), 32'(i + 1));
      check_eq("seq_id_pc", 32'(bus.id_pc), 32'(i));
      check_eq("seq_valid", 32'(bus.id_valid), 32'd1);
      check_eq("seq_instr", bus.id_instr, exp_q.pop_front());
      check_eq("seq_ctrl", 32'(ctrl_vec), 32'(exp_ctrl[i]));
      check_eq("seq_rs1", 32'(bus.regAdx1), 32'd1);
      check_eq("seq_rs2", 32'(bus.regAdx2), 32'(exp_rs2[i]));
      check_eq("seq_wadx", 32'(bus.writeAdx), 32'(exp_wadx[i]));
      check_eq("seq_imd", bus.imd, exp_imd[i]);
    end

    // Jump to 0x10 from address 2: one bubble
    load_word(7'd0, I_ADDI);
    load_word(7'd1, I_RTYPE);
    load_word(7'd2, I_J10);
    load_word(7'h10, I_ADDI2);
    load_word(7'h11, I_RTYPE);
    release_load();
    repeat (3) tick();
    check_eq("j_id_pc", 32'(bus.id_pc), 32'd2);
    check_eq("j_ctrl", 32'(ctrl_vec), 32'(C_J));
    tick();
    check_eq("j_pc", 32'(bus.pc), 32'h10);
    check_eq("j_bubble", 32'(bus.id_valid), 32'd0);
    check_eq("j_bubble_ctrl", 32'(ctrl_vec), 32'd0);
    tick();
    check_eq("j_after_valid", 32'(bus.id_valid), 32'd1);
    check_eq("j_after_id_pc", 32'(bus.id_pc), 32'h10);
    check_eq("j_after_instr", bus.id_instr, I_ADDI2);
    check_eq("j_after_pc", 32'(bus.pc), 32'h11);

    // BEQ at 5 with imd -3, taken in EX two cycles later
    for (int a = 0; a < 5; a++) load_word(7'(a), I_ADDI);
    load_word(7'd5, I_BEQ);
    load_word(7'd6, I_ADDI);
    load_word(7'd7, I_ADDI);
    release_load();
    repeat (6) tick();
    check_eq("beq_id_pc", 32'(bus.id_pc), 32'd5);
    check_eq("beq_ctrl", 32'(ctrl_vec), 32'(C_BEQ));
    check_eq("beq_target", 32'(bus.br_target_id), 32'd3);
    check_eq("beq_imd", bus.imd, 32'hFFFF_FFFD);
    tick();
    check_eq("beq_pc7", 32'(bus.pc), 32'd7);
    bus.br_taken_ex = 1'b1; bus.br_target_ex = 7'd3;
    tick();
    bus.br_taken_ex = 1'b0;
    check_eq("br_pc", 32'(bus.pc), 32'd3);
    check_eq("br_flush_valid", 32'(bus.id_valid), 32'd0);
    check_eq("br_flush_ctrl", 32'(ctrl_vec), 32'd0);
    check_eq("br_flush_instr", bus.id_instr, 32'd0);
    tick();
    check_eq("br_after_pc", 32'(bus.pc), 32'd4);
    check_eq("br_after_id_pc", 32'(bus.id_pc), 32'd3);
    check_eq("br_after_valid", 32'(bus.id_valid), 32'd1);

    // Stall 3 cycles, then stall + branch: branch wins
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_pc", 32'(bus.pc), 32'd4);
      check_eq("stall_id_pc", 32'(bus.id_pc), 32'd3);
      check_eq("stall_instr", bus.id_instr, I_ADDI);
      check_eq("stall_ctrl", 32'(ctrl_vec), 32'(C_ADDI));
    end
    bus.br_taken_ex = 1'b1; bus.br_target_ex = 7'd0;
    tick();
    check_eq("stall_br_pc", 32'(bus.pc), 32'd0);
    check_eq("stall_br_valid", 32'(bus.id_valid), 32'd0);
    bus.stall = 1'b0; bus.br_taken_ex = 1'b0;
    tick();
    check_eq("resume_pc", 32'(bus.pc), 32'd1);
    check_eq("resume_id_pc", 32'(bus.id_pc), 32'd0);

    // PC wrap 127 -> 0 and illegal opcode
    load_word(7'd0, I_J126);
    load_word(7'd126, I_ADDI2);
    load_word(7'd127, I_BAD);
    release_load();
    repeat (2) tick();
    check_eq("wrap_pc126", 32'(bus.pc), 32'd126);
    tick();
    check_eq("wrap_pc127", 32'(bus.pc), 32'd127);
    tick();
    check_eq("wrap_pc0", 32'(bus.pc), 32'd0);
    check_eq("ill_valid", 32'(bus.id_valid), 32'd1);
    check_eq("ill_flag", 32'(bus.illegal), 32'd1);
    check_eq("ill_regwr", 32'(bus.regWR), 32'd0);
    check_eq("ill_memwr", 32'(bus.MemWrEn), 32'd0);

    // Async reset mid-cycle while a jump sits in ID
    tick();
    check_eq("pre_rst_j", 32'(bus.j), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_pc", 32'(bus.pc), 32'd0);
    check_eq("arst_valid", 32'(bus.id_valid), 32'd0);
    check_eq("arst_instr", bus.id_instr, 32'd0);
    check_eq("arst_ctrl", 32'(ctrl_vec), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_pc", 32'(bus.pc), 32'd1);
    check_eq("post_rst_id_pc", 32'(bus.id_pc), 32'd0);
    check_eq("post_rst_imem", bus.id_instr, I_J126);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pipelined_fetch_decode.md
Name: pipelined_fetch_decode

Overview:
- Parametrised front end of the pipelined CPU: loadable instruction memory, PC register, IF/ID pipeline register and main opcode decoder in one block.
- Adds stall, flush, jump redirect and EX-resolved branch redirect, none of which the single-cycle control path supports.
- Feeds the register file, ALU-source mux and ID/EX register downstream; takes hazard and branch-resolution feedback from EX.

Parameters:
ADDR_W, 7, PC / instruction-memory address width (word addressed)
DEPTH, 128, instruction memory words; must equal 2**ADDR_W
RESET_PC, 0, PC value after reset and while loading

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
load_en  in  1  program-load mode: write imem, hold pipeline empty
load_adx  in  ADDR_W  imem write address in load mode
instr_in  in  32  imem write data in load mode
stall  in  1  hazard unit: hold PC and IF/ID this cycle
br_taken_ex  in  1  branch in EX resolved taken
br_target_ex  in  ADDR_W  redirect address from EX
pc  out  ADDR_W  current fetch address
id_pc  out  ADDR_W  PC of instruction in ID
id_valid  out  1  ID holds a real instruction
id_instr  out  32  instruction in ID (zero when invalid)
regAdx1, regAdx2  out  5  id_instr[25:21], id_instr[20:16]
writeAdx  out  5  RegDst ? id_instr[15:11] : id_instr[20:16]
imd  out  32  sign-extended id_instr[15:0]
br_target_id  out  ADDR_W  id_pc + 1 + imd[ADDR_W-1:0], mod 2**ADDR_W
j, br, regWR, Mem2Reg, MemWrEn, ALUsrc, RegDst  out  1 each  decoded controls
ALUop  out  2  ALU operation class
illegal  out  1  id_valid and unknown opcode

Behaviour:
- Reset (async, while rst=1): pc=RESET_PC, id_valid=0, id_pc=0, id_instr=0; all controls 0. Imem contents not reset.
- Imem: combinational read at pc; synchronous write when load_en (imem[load_adx]<=instr_in).
- Next-state priority per edge: rst > load_en > br_taken_ex > stall > ID jump > sequential.
  - load_en: pc<=RESET_PC, id_valid<=0.
  - br_taken_ex: pc<=br_target_ex, id_valid<=0 (flush; fetched instruction discarded). Overrides stall.
  - stall: pc, id_pc, id_instr, id_valid all hold.
  - ID jump (id_valid and opcode 000010): pc<=id_instr[ADDR_W-1:0], id_valid<=0 (one bubble).
  - else: pc<=pc+1 (wraps DEPTH-1 -> 0), IF/ID <= {pc, imem[pc]}, id_valid<=1.
- Branch latency: taken branch costs 2 bubbles, jump 1. Branch outcome is never decided here; br and br_target_id are passed on to EX.
- Decode (opcode = id_instr[31:26]), outputs {regWR,Mem2Reg,MemWrEn,ALUsrc,RegDst,br,j,ALUop}:
  - 000000 R-type: 1,0,0,0,1,0,0,10
  - 100011 LW: 1,1,0,1,0,0,0,00
  - 101011 SW: 0,0,1,1,0,0,0,00
  - 001000 ADDI: 1,0,0,1,0,0,0,00
  - 000100 BEQ: 0,0,0,0,0,1,0,01
  - 000010 J: 0,0,0,0,0,0,1,00
  - other opcodes: all 0; illegal=1 while valid.
- All decoded controls and illegal are forced 0 when id_valid=0. Bubbles never write registers or memory.
- Reset mid-stream clears the pipeline immediately; the first fetch after release is at RESET_PC.
- Dropping load_en: the next cycle fetches RESET_PC, and the first valid ID appears 1 cycle later.

Test Plan:
- Load 4 words at 0..3 (ADDI, R-type, LW, SW), release load_en -> pc 0,1,2,3; id_valid rises 1 cycle after release; decoded vectors match the table.
- J target 0x10 at addr 2 -> after J reaches ID, pc=0x10 next edge, exactly one id_valid=0 cycle, then id_pc=0x10.
- BEQ at addr 5, imd=-3; drive br_taken_ex=1 with br_target_ex=br_target_id=3 two cycles later -> br_target_id=3, pc=3 next edge, ID flushed, controls 0.
- stall=1 for 3 cycles -> pc and id_instr frozen, controls stable; stall and br_taken_ex together -> redirect wins.
- pc at 127 with sequential flow -> next pc=0; opcode 111111 valid in ID -> illegal=1, regWR=0, MemWrEn=0.
- Assert rst asynchronously mid-cycle during a jump -> pc=RESET_PC and id_valid=0 before the next edge; imem contents unchanged.
